// File: rtl/cla_pkg.sv
// Shared defaults and stage-count derivation for the pipelined carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 32;
    localparam int unsigned CLA_SEG   = 8;

    function automatic int unsigned cla_nstage(input int unsigned width, input int unsigned seg);
        return (seg == 0) ? 0 : width / seg;
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead adder; also exposes the carry into its MSB.
module cla_seg
    import cla_pkg::*;
#(
    parameter int unsigned SEG = CLA_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG-1:0] g;
    logic [SEG-1:0] p;
    logic [SEG:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Each carry is the flattened lookahead sum of products, not a ripple chain.
    always_comb begin
        logic term;
        term = 1'b0;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
            term = ci;
            for (int m = 0; m <= i; m++) begin
                term = term & p[m];
            end
            c[i+1] = c[i+1] | term;
        end
    end

    assign s     = p ^ c[SEG-1:0];
    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder, one CLA segment per stage, valid/ready handshake with global stall.
// Define CLA_PIPE_ADDER_OVF_EN to add the registered two's-complement overflow port ovf.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int unsigned WIDTH = CLA_WIDTH,
    parameter int unsigned SEG   = CLA_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c0,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef CLA_PIPE_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int unsigned NSTAGE = cla_nstage(WIDTH, SEG);

    if ((SEG < 2) || (NSTAGE < 1) || ((WIDTH % SEG) != 0)) begin : g_bad_cfg
        $error("cla_pipe_adder: WIDTH must be a nonzero multiple of SEG and SEG >= 2");
    end

    logic [WIDTH-1:0] a_q [NSTAGE];
    logic [WIDTH-1:0] b_q [NSTAGE];
    logic [WIDTH-1:0] s_q [NSTAGE];
    logic             c_q [NSTAGE];
    logic             v_q [NSTAGE];

    logic [WIDTH-1:0] a_in [NSTAGE];
    logic [WIDTH-1:0] b_in [NSTAGE];
    logic             c_in [NSTAGE];
    logic [WIDTH-1:0] s_d  [NSTAGE];

    logic [SEG-1:0]   seg_s  [NSTAGE];
    logic             seg_co [NSTAGE];
    logic             seg_cm [NSTAGE];

    logic             advance;
    logic             unused_tail;

    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign sum       = s_q[NSTAGE-1];
    assign cout      = c_q[NSTAGE-1];
    assign out_valid = v_q[NSTAGE-1];

    // Full operand words ride along so stage k can pick its own segment.
    always_comb begin
        a_in[0] = a;
        b_in[0] = b;
        c_in[0] = c0;
        for (int k = 1; k < NSTAGE; k++) begin
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    always_comb begin
        s_d[0]          = '0;
        s_d[0][SEG-1:0] = seg_s[0];
        for (int k = 1; k < NSTAGE; k++) begin
            s_d[k]                = s_q[k-1];
            s_d[k][k*SEG +: SEG]  = seg_s[k];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_seg
        cla_seg #(
            .SEG (SEG)
        ) u_seg (
            .a     (a_in[k][k*SEG +: SEG]),
            .b     (b_in[k][k*SEG +: SEG]),
            .ci    (c_in[k]),
            .s     (seg_s[k]),
            .co    (seg_co[k]),
            .c_msb (seg_cm[k])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
                v_q[k] <= 1'b0;
            end
        end else if (advance) begin
            v_q[0] <= in_valid;
            for (int k = 1; k < NSTAGE; k++) begin
                v_q[k] <= v_q[k-1];
            end
            for (int k = 0; k < NSTAGE; k++) begin
                a_q[k] <= a_in[k];
                b_q[k] <= b_in[k];
                s_q[k] <= s_d[k];
                c_q[k] <= seg_co[k];
            end
        end
    end

`ifdef CLA_PIPE_ADDER_OVF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (advance) begin
            ovf <= seg_cm[NSTAGE-1] ^ seg_co[NSTAGE-1];
        end
    end
`endif

    // Last-stage operand copies and the per-segment MSB carries have no consumer.
    always_comb begin
        unused_tail = ^{a_q[NSTAGE-1], b_q[NSTAGE-1]};
        for (int k = 0; k < NSTAGE; k++) begin
            unused_tail = unused_tail ^ seg_cm[k];
        end
    end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Scoreboard bench for cla_pipe_adder at WIDTH=32, SEG=8; ovf is also checked when
// CLA_PIPE_ADDER_OVF_EN is defined.
module tb_cla_pipe_adder;

    localparam int unsigned W   = 32;
    localparam int unsigned NST = 4;
`ifdef CLA_PIPE_ADDER_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
`endif

    typedef logic [W+1:0] res_t;  // {ovf, cout, sum}

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic         c0, in_valid, in_ready;
    logic [W-1:0] sum;
    logic         cout, out_valid, out_ready, ovf_w;
    res_t         obs, exp_r;

    res_t         sb [$];
    res_t         qe [$];
    logic [W-1:0] qa [$];
    logic [W-1:0] qb [$];
    logic         qc [$];

    int compared   = 0;
    int mismatched = 0;

    cla_pipe_adder #(
        .WIDTH (W),
        .SEG   (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .c0        (c0),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum       (sum),
        .cout      (cout),
`ifdef CLA_PIPE_ADDER_OVF_EN
        .ovf       (ovf_w),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

`ifndef CLA_PIPE_ADDER_OVF_EN
    assign ovf_w = 1'b0;
`endif
    assign obs = {ovf_w, cout, sum};

    always #5 clk = ~clk;

    function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
        logic [W:0] t;
        logic       v;
        t = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        v = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
        return {HAS_OVF & v, t};
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Drive one cycle at the falling edge, then let outputs settle.
    task automatic offer(input logic rdy, input logic go);
        @(negedge clk);
        in_valid = go && (qa.size() != 0);
        if (in_valid) begin
            a  = qa[0];
            b  = qb[0];
            c0 = qc[0];
        end
        out_ready = rdy;
        #1;
    endtask

    task automatic note_accept();
        if (in_valid && in_ready) begin
            if (qe.size() != 0) sb.push_back(qe.pop_front());
            else sb.push_back(model(qa[0], qb[0], qc[0]));
            qa.delete(0);
            qb.delete(0);
            qc.delete(0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c0 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        compared++;
        if ({out_valid, obs} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: got valid=%b res=%h, need 0/0", out_valid, obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compared++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b, need 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_single();
        int t_acc = -1;
        int t_out = -1;
        qa.push_back(32'd10); qb.push_back(32'd10); qc.push_back(1'b0);
        qe.push_back({2'b00, 32'd20});
        for (int i = 0; i < 20 && t_out < 0; i++) begin
            offer(1'b1, 1'b1);
            if (in_valid && in_ready) t_acc = i;
            note_accept();
            if (out_valid) begin
                t_out = i;
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL single: got %h, need %h", obs, exp_r);
                end
            end
        end
        compared++;
        if (t_out - t_acc != NST) begin
            mismatched++;
            $display("FAIL single_latency: got %0d, need %0d", t_out - t_acc, NST);
        end
    endtask

    task automatic test_carry();
        qa.push_back(32'hFFFF_FFFF); qb.push_back(32'h0);         qc.push_back(1'b1);
        qe.push_back({1'b0, 1'b1, 32'h0});
        qa.push_back(32'hFFFF_FFFF); qb.push_back(32'hFFFF_FFFF); qc.push_back(1'b1);
        qe.push_back({1'b0, 1'b1, 32'hFFFF_FFFF});
        qa.push_back(32'h7FFF_FFFF); qb.push_back(32'h1);         qc.push_back(1'b0);
        qe.push_back({HAS_OVF, 1'b0, 32'h8000_0000});
        qa.push_back(32'hFFFF_FFFF); qb.push_back(32'h1);         qc.push_back(1'b0);
        qe.push_back({1'b0, 1'b1, 32'h0});
        qa.push_back(32'h8000_0000); qb.push_back(32'h8000_0000); qc.push_back(1'b0);
        qe.push_back({HAS_OVF, 1'b1, 32'h0});
        qa.push_back(32'h00FF_00FF); qb.push_back(32'h0001_0001); qc.push_back(1'b0);
        qe.push_back({1'b0, 1'b0, 32'h0100_0100});
        for (int i = 0; i < 40 && (qa.size() != 0 || sb.size() != 0); i++) begin
            offer(1'b1, 1'b1);
            note_accept();
            if (out_valid) begin
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL carry: got %h, need %h", obs, exp_r);
                end
            end
        end
        compared++;
        if (qa.size() != 0 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL carry_drain: got %0d pending, need 0", qa.size() + sb.size());
        end
    endtask

    task automatic test_back_to_back();
        int prev  = -1;
        int n_out = 0;
        for (int i = 0; i < 8; i++) begin
            qa.push_back(W'(i)); qb.push_back(W'(2 * i)); qc.push_back(1'b0);
            qe.push_back({2'b00, W'(3 * i)});
        end
        for (int i = 0; i < 30 && (qa.size() != 0 || sb.size() != 0); i++) begin
            offer(1'b1, 1'b1);
            note_accept();
            if (out_valid) begin
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL b2b: got %h, need %h", obs, exp_r);
                end
                if (prev >= 0) begin
                    compared++;
                    if (i != prev + 1) begin
                        mismatched++;
                        $display("FAIL b2b_gap: got gap %0d, need 1", i - prev);
                    end
                end
                prev = i;
                n_out++;
            end
        end
        compared++;
        if (n_out != 8) begin
            mismatched++;
            $display("FAIL b2b_count: got %0d, need 8", n_out);
        end
    endtask

    task automatic test_stall();
        int held  = 0;
        int n_out = 0;
        for (int i = 0; i < 6; i++) begin
            qa.push_back(32'h1234_5678 * (i + 1)); qb.push_back(32'hFEDC_BA98 ^ W'(i));
            qc.push_back(i[0]);
        end
        for (int i = 0; i < 60 && (qa.size() != 0 || sb.size() != 0); i++) begin
            offer(held >= 5, 1'b1);
            note_accept();
            if (!out_ready && out_valid) begin
                held++;
                compared++;
                if (in_ready !== 1'b0) begin
                    mismatched++;
                    $display("FAIL stall_in_ready: got %b, need 0", in_ready);
                end
                compared++;
                if (sb.size() == 0 || obs !== sb[0]) begin
                    mismatched++;
                    $display("FAIL stall_hold: got %h, need %h", obs, sb[0]);
                end
            end else if (out_valid) begin
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL stall_out: got %h, need %h", obs, exp_r);
                end
                n_out++;
            end
        end
        compared++;
        if (n_out != 6 || held != 5) begin
            mismatched++;
            $display("FAIL stall_count: got out=%0d held=%0d, need 6/5", n_out, held);
        end
    endtask

    task automatic test_reset_flight();
        int t_acc = -1;
        int t_out = -1;
        for (int i = 0; i < 4; i++) begin
            qa.push_back(32'hA5A5_0000 + W'(i)); qb.push_back(32'h0F0F_F0F0); qc.push_back(1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            offer(1'b0, 1'b1);
            note_accept();
            if (out_valid) break;
        end
        compared++;
        if (out_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL flight_fill: got out_valid=%b, need 1", out_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if ({out_valid, obs} !== '0) begin
            mismatched++;
            $display("FAIL flight_async_reset: got valid=%b res=%h, need 0/0", out_valid, obs);
        end
        sb.delete(); qe.delete(); qa.delete(); qb.delete(); qc.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            offer(1'b1, 1'b1);
            compared++;
            if (out_valid !== 1'b0) begin
                mismatched++;
                $display("FAIL flight_stale: got out_valid=%b res=%h, need 0", out_valid, obs);
            end
        end
        qa.push_back(32'd5); qb.push_back(32'd6); qc.push_back(1'b1);
        qe.push_back({2'b00, 32'd12});
        for (int i = 0; i < 20 && t_out < 0; i++) begin
            offer(1'b1, 1'b1);
            if (in_valid && in_ready) t_acc = i;
            note_accept();
            if (out_valid) begin
                t_out = i;
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL flight_fresh: got %h, need %h", obs, exp_r);
                end
            end
        end
        compared++;
        if (t_out - t_acc != NST) begin
            mismatched++;
            $display("FAIL flight_latency: got %0d, need %0d", t_out - t_acc, NST);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            qa.push_back(pick()); qb.push_back(pick()); qc.push_back(1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 600 && (qa.size() != 0 || sb.size() != 0); i++) begin
            offer($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
            note_accept();
            if (out_valid && out_ready) begin
                if (sb.size() == 0) exp_r = 'x; else exp_r = sb.pop_front();
                compared++;
                if (obs !== exp_r) begin
                    mismatched++;
                    $display("FAIL random: got %h, need %h", obs, exp_r);
                end
            end
        end
        compared++;
        if (qa.size() != 0 || sb.size() != 0) begin
            mismatched++;
            $display("FAIL random_drain: got %0d pending, need 0", qa.size() + sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_carry();
        test_back_to_back();
        test_stall();
        test_reset_flight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, compared=%0d", compared);
        $fatal(1, "timeout");
    end

endmodule
